// File: rtl/hilo_mdu_ctrl_pkg.sv
// rtl/hilo_mdu_ctrl_pkg.sv - MDU FSM state encodings, funct codes and sign helper
package hilo_mdu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } mdu_state_t;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] FUNC_MTHI  = 6'b010001;
   localparam logic [5:0] FUNC_MTLO  = 6'b010011;
   localparam logic [5:0] FUNC_MULT  = 6'b011000;
   localparam logic [5:0] FUNC_MULTU = 6'b011001;
   localparam logic [5:0] FUNC_DIV   = 6'b011010;
   localparam logic [5:0] FUNC_DIVU  = 6'b011011;

   // Magnitude of x when treated as signed, otherwise x unchanged.
   function automatic logic [31:0] abs_if(input logic [31:0] x, input logic en);
      return (en && x[31]) ? 32'(-x) : x;
   endfunction

endpackage

// File: rtl/hilo_mdu_ctrl_div_iter.sv
// rtl/hilo_mdu_ctrl_div_iter.sv - restoring unsigned divider, one quotient bit per enable
module div_iter (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic        i_en,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic [31:0] o_quo,
   output logic [31:0] o_rem
);

   logic [31:0] r_quo;
   logic [31:0] r_rem;
   logic [31:0] r_div;
   logic [32:0] w_shift;
   logic [32:0] w_diff;

   // r_quo doubles as the dividend shift register; quotient bits enter at the bottom.
   assign w_shift = {r_rem, r_quo[31]};
   assign w_diff  = w_shift - {1'b0, r_div};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_quo <= '0;
         r_rem <= '0;
         r_div <= '0;
      end else if (i_load) begin
         r_quo <= i_dividend;
         r_rem <= '0;
         r_div <= i_divisor;
      end else if (i_en) begin
         r_rem <= w_diff[32] ? w_shift[31:0] : w_diff[31:0];
         r_quo <= {r_quo[30:0], ~w_diff[32]};
      end
   end

   assign o_quo = r_quo;
   assign o_rem = r_rem;

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// rtl/hilo_mdu_ctrl.sv - execute-stage multiply/divide sequencer owning HI/LO
module hilo_mdu_ctrl
   import hilo_mdu_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 3
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_op_valid,
   input  logic [5:0]  i_op,
   input  logic [5:0]  i_funct,
   input  logic [31:0] i_rs_val,
   input  logic [31:0] i_rt_val,
   input  logic        i_flush,
   output logic        o_stall,
   output logic        o_busy,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);

   localparam logic [4:0] LP_MUL_CNT = 5'(MUL_LAT - 1);

   mdu_state_t  r_state;
   logic [4:0]  r_cnt;
   logic [31:0] r_hi, r_lo, r_a, r_b;
   logic        r_sgn, r_dz, r_neg_q, r_neg_r;

   logic        w_issue, w_is_md, w_is_mul, w_signed, w_start;
   logic [63:0] w_a64, w_b64, w_prod;
   logic [31:0] w_quo, w_rem;

   assign w_issue  = i_op_valid && (i_op == OP_SPECIAL) && !i_flush;
   assign w_is_md  = (i_funct == FUNC_MULT) || (i_funct == FUNC_MULTU) ||
                     (i_funct == FUNC_DIV)  || (i_funct == FUNC_DIVU);
   assign w_is_mul = (i_funct == FUNC_MULT) || (i_funct == FUNC_MULTU);
   assign w_signed = (i_funct == FUNC_MULT) || (i_funct == FUNC_DIV);
   assign w_start  = w_issue && w_is_md && (r_state == ST_IDLE);

   // Low 64 bits of the extended product are correct for both signed and unsigned.
   assign w_a64  = {{32{r_sgn & r_a[31]}}, r_a};
   assign w_b64  = {{32{r_sgn & r_b[31]}}, r_b};
   assign w_prod = w_a64 * w_b64;

   div_iter u_div (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_start),
      .i_en       (r_state == ST_DIV),
      .i_dividend (abs_if(i_rs_val, w_signed)),
      .i_divisor  (abs_if(i_rt_val, w_signed)),
      .o_quo      (w_quo),
      .o_rem      (w_rem)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sgn   <= 1'b0;
         r_dz    <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_a     <= i_rs_val;
                  r_b     <= i_rt_val;
                  r_sgn   <= w_signed;
                  r_dz    <= (i_rt_val == '0);
                  r_neg_q <= w_signed && (i_rs_val[31] ^ i_rt_val[31]);
                  r_neg_r <= w_signed && i_rs_val[31];
                  if (w_is_mul) begin
                     r_state <= ST_MUL;
                     r_cnt   <= LP_MUL_CNT;
                  end else if (i_rt_val == '0) begin
                     r_state <= ST_FIX;
                  end else begin
                     r_state <= ST_DIV;
                     r_cnt   <= 5'd31;
                  end
               end else if (w_issue && i_funct == FUNC_MTHI) begin
                  r_hi <= i_rs_val;
               end else if (w_issue && i_funct == FUNC_MTLO) begin
                  r_lo <= i_rs_val;
               end
            end
            ST_MUL: begin
               if (i_flush) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt == '0) begin
                  {r_hi, r_lo} <= w_prod;
                  r_state      <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt - 5'd1;
               end
            end
            ST_DIV: begin
               if (i_flush)            r_state <= ST_IDLE;
               else if (r_cnt == '0)   r_state <= ST_FIX;
               else                    r_cnt   <= r_cnt - 5'd1;
            end
            ST_FIX: begin
               if (i_flush) begin
                  r_state <= ST_IDLE;
               end else begin
                  if (r_dz) begin
                     r_lo <= 32'hFFFF_FFFF;
                     r_hi <= r_a;
                  end else begin
                     r_lo <= r_neg_q ? 32'(-w_quo) : w_quo;
                     r_hi <= r_neg_r ? 32'(-w_rem) : w_rem;
                  end
                  r_state <= ST_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // A flush releases the pipeline in the same cycle it kills the operation.
   assign o_stall = w_start ||
                    (((r_state == ST_MUL) || (r_state == ST_DIV) || (r_state == ST_FIX)) && !i_flush);
   assign o_busy  = (r_state != ST_IDLE);
   assign o_hi    = r_hi;
   assign o_lo    = r_lo;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb/tb_hilo_mdu_ctrl.sv - directed self-checking bench with a cycle-level behavioural model
module tb_hilo_mdu_ctrl;

   localparam int MUL_LAT = 3;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic        clk = 1'b0;
   logic        rst, op_valid, flush;
   logic [5:0]  op, funct;
   logic [31:0] rs, rt;
   logic        stall, busy;
   logic [31:0] hi, lo;

   bit          m_chk = 1'b0;
   logic        m_stall, m_busy;
   logic [31:0] m_hi, m_lo;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   hilo_mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .i_clk(clk), .i_rst(rst), .i_op_valid(op_valid), .i_op(op), .i_funct(funct),
      .i_rs_val(rs), .i_rt_val(rt), .i_flush(flush),
      .o_stall(stall), .o_busy(busy), .o_hi(hi), .o_lo(lo)
   );

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_chk) begin
         cmp("stall", {31'b0, stall}, {31'b0, m_stall});
         cmp("busy",  {31'b0, busy},  {31'b0, m_busy});
         cmp("hi", hi, m_hi);
         cmp("lo", lo, m_lo);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Architectural result and stall length of one MDU instruction.
   task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output int len);
      longint          ps;
      longint unsigned pu;
      int              q, r;
      h = '0; l = '0; len = 0;
      case (f)
         F_MULT: begin
            ps = longint'($signed(a)) * longint'($signed(b));
            {h, l} = ps;
            len = MUL_LAT + 1;
         end
         F_MULTU: begin
            pu = {32'b0, a} * {32'b0, b};
            {h, l} = pu;
            len = MUL_LAT + 1;
         end
         default: begin
            if (b == 0) begin
               l = 32'hFFFF_FFFF; h = a; len = 2;
            end else begin
               len = 34;
               if (f == F_DIVU) begin
                  l = a / b; h = a % b;
               end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  l = 32'h8000_0000; h = 0;
               end else begin
                  q = $signed(a) / $signed(b);
                  r = $signed(a) % $signed(b);
                  l = q; h = r;
               end
            end
         end
      endcase
   endtask

   // Runs an MDU op from its start cycle through DONE; kill_at>=1 flushes or resets in that cycle.
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int kill_at, input bit kill_rst);
      logic [31:0] nh, nl;
      int          len;
      model(f, a, b, nh, nl, len);
      for (int c = 0; c <= len; c++) begin
         op_valid = 1'b1; op = 6'd0; funct = f; flush = 1'b0; rst = 1'b0;
         if (c == 0) begin rs = a; rt = b; end
         else begin rs = ~a; rt = b ^ 32'h5A5A_0001; end
         m_stall = (c < len);
         m_busy  = (c > 0);
         if (c == len) begin m_hi = nh; m_lo = nl; end
         if (c == kill_at) begin
            if (kill_rst) rst = 1'b1;
            else begin flush = 1'b1; m_stall = 1'b0; end
         end
         step();
         if (c == kill_at) begin
            if (kill_rst) begin m_hi = '0; m_lo = '0; end
            return;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         op_valid = 1'b0; flush = 1'b0; rst = 1'b0; rs = $urandom; rt = $urandom;
         m_stall = 1'b0; m_busy = 1'b0;
         step();
      end
   endtask

   // Single-cycle non-stalling instruction (MT*/MF*, or anything while flushed).
   task automatic single(input logic [5:0] f, input logic [31:0] a, input bit fl);
      op_valid = 1'b1; op = 6'd0; funct = f; rs = a; rt = $urandom; flush = fl; rst = 1'b0;
      m_stall = 1'b0; m_busy = 1'b0;
      step();
      if (!fl && f == F_MTHI) m_hi = a;
      if (!fl && f == F_MTLO) m_lo = a;
   endtask

   initial begin
      rst = 1'b1; op_valid = 1'b0; flush = 1'b0; op = 6'd0; funct = 6'd0; rs = '0; rt = '0;
      m_stall = 1'b0; m_busy = 1'b0; m_hi = '0; m_lo = '0;
      step();
      step();
      m_chk = 1'b1;
      idle(2);
      cmp("reset_hi", hi, 32'h0);
      cmp("reset_lo", lo, 32'h0);

      single(F_MTHI, 32'h1234_5678, 1'b0);
      single(F_MFHI, 32'h0, 1'b0);
      cmp("mthi_hi", hi, 32'h1234_5678);
      cmp("mthi_lo", lo, 32'h0);

      issue(F_MULT, 32'hFFFF_FFFE, 32'd3, -1, 1'b0);
      cmp("mult_hi", hi, 32'hFFFF_FFFF);
      cmp("mult_lo", lo, 32'hFFFF_FFFA);
      issue(F_MULTU, 32'hFFFF_FFFE, 32'd3, -1, 1'b0);
      cmp("multu_hi", hi, 32'h0000_0002);
      cmp("multu_lo", lo, 32'hFFFF_FFFA);

      issue(F_DIV, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
      cmp("div_lo", lo, 32'hFFFF_FFFD);
      cmp("div_hi", hi, 32'hFFFF_FFFF);
      issue(F_DIVU, 32'd100, 32'd7, -1, 1'b0);
      cmp("divu_lo", lo, 32'd14);
      cmp("divu_hi", hi, 32'd2);
      issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
      cmp("ovf_lo", lo, 32'h8000_0000);
      cmp("ovf_hi", hi, 32'h0);
      issue(F_DIVU, 32'd5, 32'd0, -1, 1'b0);
      cmp("dz_lo", lo, 32'hFFFF_FFFF);
      cmp("dz_hi", hi, 32'd5);
      idle(1);

      single(F_MTLO, 32'hCAFE_F00D, 1'b0);
      single(F_MTLO, 32'h1111_1111, 1'b1);
      single(F_MULT, 32'd7, 1'b1);
      single(F_MFLO, 32'h0, 1'b0);
      cmp("flush_idle_lo", lo, 32'hCAFE_F00D);

      issue(F_DIVU, 32'hDEAD_BEEF, 32'h0000_1234, 10, 1'b0);
      idle(1);
      cmp("flush_hi", hi, 32'd5);
      cmp("flush_lo", lo, 32'hCAFE_F00D);

      issue(F_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFFD, -1, 1'b0);
      issue(F_DIV, 32'd9, 32'hFFFF_FFFC, -1, 1'b0);
      issue(F_MULT, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);
      cmp("mult_min_hi", hi, 32'h4000_0000);
      issue(F_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, -1, 1'b0);
      issue(F_DIV, 32'hFFFF_FF00, 32'd0, -1, 1'b0);

      issue(F_DIVU, 32'd1000, 32'd3, 20, 1'b1);
      idle(2);
      cmp("rst_mid_hi", hi, 32'h0);
      cmp("rst_mid_lo", lo, 32'h0);

      m_chk = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hilo_mdu_ctrl.md
# hilo_mdu_ctrl

Execute-stage multiply/divide unit controller that owns the architectural HI/LO register pair. It sequences MULT/MULTU (fixed-latency) and DIV/DIVU (32-step iterative), and stalls the pipeline while an operation is in flight. It commits results to HI/LO and serves MTHI/MTLO writes and MFHI/MFLO reads. It sits beside the ALU in the execute stage and is driven by the decoded R-type instruction fields and the forwarded rs/rt operands.

## Interface
- `MUL_LAT`, default 3: number of MUL-state cycles, range 1–8.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `op_valid` input 1: a valid instruction is in the execute stage.
- `op` input 6: instruction opcode field.
- `funct` input 6: instruction funct field.
- `rs_val` input 32: forwarded rs operand. Dividend or multiplicand. Source for MTHI/MTLO.
- `rt_val` input 32: forwarded rt operand. Divisor or multiplier.
- `flush` input 1: kill the in-flight operation.
- `stall` output 1: freezes the IF/ID/EX pipeline registers.
- `busy` output 1: the FSM is not in IDLE.
- `hi` output 32: current HI register, registered.
- `lo` output 32: current LO register, registered.

## Operation
- Start condition `mdu_start` = `op_valid` & `op`==000000 & `funct`∈{MULT 011000, MULTU 011001, DIV 011010, DIVU 011011} & state==IDLE & !`flush`.
- FSM states:
  - **IDLE**
    - On `mdu_start`:
      - Latch operands, sign flags and operation kind.
      - Go to MUL for multiply ops.
      - Go to FIX for a divide with rt_val==0.
      - Go to DIV for any other divide, loading the counter with 31.
    - With op_valid, op==0, funct MTHI (010001): HI←rs_val at the next edge.
    - With op_valid, op==0, funct MTLO (010011): LO←rs_val at the next edge.
    - MFHI (010000) and MFLO (010010) need no action; `hi`/`lo` are always valid.
  - **MUL**
    - Counts MUL_LAT cycles.
    - The last cycle writes {HI,LO}←64-bit product (signed or unsigned), then goes to DONE.
  - **DIV**
    - One restoring step per cycle on operand magnitudes: 32-bit quotient plus 33-bit partial remainder.
    - Counter reaches 0 → go to FIX.
  - **FIX**
    - Applies signs: quotient negated if sign(rs)^sign(rt); remainder negated if sign(rs). Signs apply only for DIV.
    - Writes LO←quotient and HI←remainder, then goes to DONE.
    - Divide-by-zero (signed or unsigned) writes LO←32'hFFFFFFFF and HI←rs_val.
  - **DONE**
    - One cycle with `stall`=0 so the MDU instruction leaves execute.
    - Unconditional return to IDLE.
- `stall` = `mdu_start` | (state∈{MUL,DIV,FIX}). Stall is combinational in the start cycle. It is low in DONE and IDLE.
- Signed overflow 0x80000000 / −1 is an expected case, not an error: it yields LO=0x80000000, HI=0.
- `flush` in MUL/DIV/FIX: return to IDLE at the next edge. HI/LO stay unchanged; `stall` drops the same cycle.
- `flush` in DONE: HI/LO are already committed. Return to IDLE.
- `flush` in IDLE: blocks both start and MTHI/MTLO writes.
- Reset: state=IDLE, HI=LO=0, counter=0, `stall`=0, `busy`=0.

## Timing
- The cycle where the instruction first appears in execute is cycle 0.
- MULT/MULTU:
  - Stall in cycles 0..MUL_LAT, which is 4 cycles by default.
  - HI/LO visible in cycle MUL_LAT+1, the DONE cycle.
- DIV/DIVU with nonzero divisor:
  - DIV in cycles 1–32, FIX in cycle 33, DONE in cycle 34.
  - Stall lasts 34 cycles. HI/LO visible in cycle 34.
- Divide-by-zero: FIX in cycle 1, DONE in cycle 2, stall lasts 2 cycles.
- MTHI/MTLO: zero stall. The value is visible on `hi`/`lo` the cycle after issue.
- A following MFHI/MFLO reads the updated value, because it reaches execute at least one cycle later.
- Back-to-back MDU ops: the second one starts in the cycle after DONE.
- Operands are sampled only in the start cycle. Later changes on rs_val/rt_val are ignored.

## Structure
- Add to `define_mdu.vh`:
  - FSM state encodings IDLE/MUL/DIV/FIX/DONE, 3 bits.
  - The MDU funct codes, reusing the FUNC_* names already in `define_instr_dec.vh` where they exist.
- Sub-module `div_iter`:
  - Restoring unsigned divide datapath: one step per enable, with 32-bit quotient and remainder outputs.
  - The FSM, sign handling, multiplier pipeline and HI/LO registers stay in `hilo_mdu_ctrl`.

## Test plan
- Reset then MTHI rs=0x12345678, then MFHI → hi=0x12345678 one cycle later, with no stall. LO stays 0.
- MULT rs=0xFFFFFFFE (−2), rt=3 → stall high 4 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV rs=−7 (0xFFFFFFF9), rt=2 → stall 34 cycles. Then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU rs=5, rt=0 → stall 2 cycles, LO=0xFFFFFFFF, HI=5.
- DIVU started, `flush` asserted in cycle 10 → stall low in cycle 10, IDLE in cycle 11, HI/LO keep their prior values.
- `rst` asserted mid-DIV (cycle 20) → the next cycle shows IDLE, stall=0, busy=0, HI=LO=0.
